alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 30 +++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Brief    : Command/result handshake bundle for the ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic        flag_c;
    logic        flag_z;
    logic        flag_err;

    modport master (
        output cmd_valid, cmd_op, op_a, op_b, res_ready,
        input  cmd_ready, res_valid, result, flag_c, flag_z, flag_err
    );

    modport slave (
        input  cmd_valid, cmd_op, op_a, op_b, res_ready,
        output cmd_ready, res_valid, result, flag_c, flag_z, flag_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : 8-bit ALU behind a valid/ready handshake, with optional 8-cycle
//            shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int MUL_ENABLE = 1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      ena,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_OR  = 3'b011;
    localparam logic [2:0] C_OP_XOR = 3'b100;
    localparam logic [2:0] C_OP_SHL = 3'b101;
    localparam logic [2:0] C_OP_SHR = 3'b110;
    localparam logic [2:0] C_OP_MUL = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        fc_q, fc_d;
    logic        fz_q, fz_d;
    logic        ferr_q, ferr_d;

    logic        w_accept;
    logic [7:0]  w_a;
    logic [2:0]  w_sh;
    logic [8:0]  w_sum;
    logic [8:0]  w_diff;
    logic [8:0]  w_shl;
    logic [8:0]  w_shr;
    logic [15:0] w_mul_sum;
    logic [15:0] w_alu_res;
    logic        w_alu_c;
    logic        w_alu_err;

    assign bus.cmd_ready = (state_q == S_IDLE) && ena;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;

    // Operand a lives in the low byte of the multiplicand, b in the multiplier.
    assign w_a       = mcand_q[7:0];
    assign w_sh      = mplier_q[2:0];
    assign w_sum     = {1'b0, w_a} + {1'b0, mplier_q};
    assign w_diff    = {1'b0, w_a} - {1'b0, mplier_q};
    // Bit 8 of w_shl and bit 0 of w_shr catch the last bit shifted out.
    assign w_shl     = {1'b0, w_a} << w_sh;
    assign w_shr     = {w_a, 1'b0} >> w_sh;
    assign w_mul_sum = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

    always_comb begin
        w_alu_res = 16'h0000;
        w_alu_c   = 1'b0;
        w_alu_err = 1'b0;
        case (op_q)
            C_OP_ADD: begin w_alu_res = {8'h00, w_sum[7:0]};  w_alu_c = w_sum[8];  end
            C_OP_SUB: begin w_alu_res = {8'h00, w_diff[7:0]}; w_alu_c = w_diff[8]; end
            C_OP_AND: w_alu_res = {8'h00, w_a & mplier_q};
            C_OP_OR:  w_alu_res = {8'h00, w_a | mplier_q};
            C_OP_XOR: w_alu_res = {8'h00, w_a ^ mplier_q};
            C_OP_SHL: begin w_alu_res = {8'h00, w_shl[7:0]};  w_alu_c = w_shl[8]; end
            C_OP_SHR: begin w_alu_res = {8'h00, w_shr[8:1]};  w_alu_c = w_shr[0]; end
            default:  w_alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        fc_d     = fc_q;
        fz_d     = fz_q;
        ferr_d   = ferr_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    mcand_d  = {8'h00, bus.op_a};
                    mplier_d = bus.op_b;
                    op_d     = bus.cmd_op;
                    acc_d    = 16'h0000;
                    cnt_d    = 3'd0;
                    state_d  = ((bus.cmd_op == C_OP_MUL) && (MUL_ENABLE != 0)) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = w_alu_res;
                fc_d     = w_alu_c;
                fz_d     = (w_alu_res == 16'h0000);
                ferr_d   = w_alu_err;
                state_d  = S_DONE;
            end
            S_MUL: begin
                acc_d    = w_mul_sum;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = w_mul_sum;
                    fc_d     = 1'b0;
                    fz_d     = (w_mul_sum == 16'h0000);
                    ferr_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            op_q     <= 3'b000;
            acc_q    <= 16'h0000;
            cnt_q    <= 3'd0;
            result_q <= 16'h0000;
            fc_q     <= 1'b0;
            fz_q     <= 1'b1;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.res_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.flag_c    = fc_q;
    assign bus.flag_z    = fz_q;
    assign bus.flag_err  = ferr_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench; MUL-enabled and MUL-disabled builds side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    alu_sequencer_if bus1();
    alu_sequencer_if bus0();

    alu_sequencer #(.MUL_ENABLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1.slave));
    alu_sequencer #(.MUL_ENABLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0.slave));

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model slot 0 tracks the MUL-enabled build, slot 1 the MUL-disabled one.
    int          m_wait [2];
    bit          m_done [2];
    logic [15:0] m_res  [2];
    logic        m_c    [2];
    logic        m_z    [2];
    logic        m_err  [2];
    logic [15:0] p_res  [2];
    logic        p_c    [2];
    logic        p_err  [2];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rr);
        bus1.cmd_valid = v;  bus0.cmd_valid = v;
        bus1.cmd_op    = op; bus0.cmd_op    = op;
        bus1.op_a      = a;  bus0.op_a      = a;
        bus1.op_b      = b;  bus0.op_b      = b;
        bus1.res_ready = rr; bus0.res_ready = rr;
    endtask

    function automatic void compute(input int op, input int a, input int b, input bit mulen,
                                    output logic [15:0] r, output logic c, output logic e,
                                    output int lat);
        int sh;
        int v;
        sh  = b % 8;
        v   = 0;
        c   = 1'b0;
        e   = 1'b0;
        lat = 2;
        case (op)
            0: begin v = a + b; c = (v > 255); v = v % 256; end
            1: begin v = (a - b + 256) % 256; c = (a < b); end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: begin v = (a * (1 << sh)) % 256; c = (sh != 0) && (((a >> (8 - sh)) % 2) == 1); end
            6: begin v = a / (1 << sh); c = (sh != 0) && (((a >> (sh - 1)) % 2) == 1); end
            default: begin
                if (mulen) begin v = a * b; lat = 9; end
                else e = 1'b1;
            end
        endcase
        r = 16'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wait[i] = 0;
            m_done[i] = 1'b0;
            m_res[i]  = 16'h0000;
            m_c[i]    = 1'b0;
            m_z[i]    = 1'b1;
            m_err[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        int lat;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_wait[i] = 0; m_done[i] = 1'b0; m_res[i] = 16'h0000;
                m_c[i] = 1'b0; m_z[i] = 1'b1; m_err[i] = 1'b0;
            end else if (m_done[i]) begin
                if (bus1.res_ready) m_done[i] = 1'b0;
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_done[i] = 1'b1;
                    m_res[i]  = p_res[i];
                    m_c[i]    = p_c[i];
                    m_err[i]  = p_err[i];
                    m_z[i]    = (p_res[i] == 16'h0000);
                end
            end else if (ena && bus1.cmd_valid) begin
                compute(int'(bus1.cmd_op), int'(bus1.op_a), int'(bus1.op_b), (i == 0),
                        p_res[i], p_c[i], p_err[i], lat);
                m_wait[i] = lat - 1;
            end
        end
    endtask

    task automatic compare_all();
        logic        rdy, vld, c, z, e;
        logic [15:0] res;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                rdy = bus1.cmd_ready; vld = bus1.res_valid; res = bus1.result;
                c = bus1.flag_c; z = bus1.flag_z; e = bus1.flag_err;
            end else begin
                rdy = bus0.cmd_ready; vld = bus0.res_valid; res = bus0.result;
                c = bus0.flag_c; z = bus0.flag_z; e = bus0.flag_err;
            end
            chk($sformatf("cmd_ready[%0d] t=%0t", i, $time), {15'd0, rdy},
                {15'd0, (!m_done[i] && m_wait[i] == 0 && ena)});
            chk($sformatf("res_valid[%0d] t=%0t", i, $time), {15'd0, vld}, {15'd0, m_done[i]});
            chk($sformatf("result[%0d] t=%0t", i, $time), res, m_res[i]);
            chk($sformatf("flag_c[%0d] t=%0t", i, $time), {15'd0, c}, {15'd0, m_c[i]});
            chk($sformatf("flag_z[%0d] t=%0t", i, $time), {15'd0, z}, {15'd0, m_z[i]});
            chk($sformatf("flag_err[%0d] t=%0t", i, $time), {15'd0, e}, {15'd0, m_err[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat1, output int lat0, output int rdy_hi);
        drive(1'b1, op, a, b, 1'b0);
        tick();
        drive(1'b0, op, ~a, ~b, 1'b0);
        lat1 = 0; lat0 = 0; rdy_hi = 0;
        for (int n = 2; n <= 20; n++) begin
            tick();
            if (lat1 == 0 && bus1.res_valid) lat1 = n;
            if (lat0 == 0 && bus0.res_valid) lat0 = n;
            if (lat1 == 0 && bus1.cmd_ready) rdy_hi++;
            if (lat1 != 0 && lat0 != 0) break;
        end
    endtask

    task automatic release_res();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int l1, l0, rh;
        rst_n = 1'b1;
        ena   = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset result", bus1.result, 16'h0000);
        chk("reset flag_z", {15'd0, bus1.flag_z}, 16'h0001);
        chk("reset res_valid", {15'd0, bus1.res_valid}, 16'h0000);
        chk("reset flag_err", {15'd0, bus0.flag_err}, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;

        // ADD with carry out
        do_op(3'd0, 8'hC8, 8'h64, l1, l0, rh);
        chk("add latency", 16'(l1), 16'd2);
        chk("add result", bus1.result, 16'h002C);
        chk("add flag_c", {15'd0, bus1.flag_c}, 16'h0001);
        chk("add flag_z", {15'd0, bus1.flag_z}, 16'h0000);
        release_res();

        // SUB borrow, then SUB to zero
        do_op(3'd1, 8'h05, 8'h07, l1, l0, rh);
        chk("sub result", bus1.result, 16'h00FE);
        chk("sub flag_c", {15'd0, bus1.flag_c}, 16'h0001);
        release_res();
        do_op(3'd1, 8'h07, 8'h07, l1, l0, rh);
        chk("sub0 result", bus1.result, 16'h0000);
        chk("sub0 flag_z", {15'd0, bus1.flag_z}, 16'h0001);
        chk("sub0 flag_c", {15'd0, bus1.flag_c}, 16'h0000);
        release_res();

        // MUL on both builds
        do_op(3'd7, 8'hFF, 8'hFF, l1, l0, rh);
        chk("mul latency", 16'(l1), 16'd9);
        chk("mul result", bus1.result, 16'hFE01);
        chk("mul cmd_ready cycles", 16'(rh), 16'd0);
        chk("nomul latency", 16'(l0), 16'd2);
        chk("nomul result", bus0.result, 16'h0000);
        chk("nomul flag_err", {15'd0, bus0.flag_err}, 16'h0001);
        release_res();

        // SHL carry, then a held result while cmd_valid pulses
        do_op(3'd5, 8'h81, 8'h01, l1, l0, rh);
        chk("shl result", bus1.result, 16'h0002);
        chk("shl flag_c", {15'd0, bus1.flag_c}, 16'h0001);
        for (int k = 0; k < 5; k++) begin
            drive(1'(k % 2), 3'(k), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            tick();
            chk("shl hold result", bus1.result, 16'h0002);
            chk("shl hold res_valid", {15'd0, bus1.res_valid}, 16'h0001);
        end
        release_res();

        // Reset in the middle of a multiply
        drive(1'b1, 3'd7, 8'hFF, 8'hFF, 1'b0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midmul reset result", bus1.result, 16'h0000);
        chk("midmul reset flag_z", {15'd0, bus1.flag_z}, 16'h0001);
        chk("midmul reset res_valid", {15'd0, bus1.res_valid}, 16'h0000);
        chk("midmul reset cmd_ready", {15'd0, bus1.cmd_ready}, 16'h0001);
        model_reset();
        compare_all();
        tick();
        rst_n = 1'b1;
        do_op(3'd0, 8'h01, 8'h01, l1, l0, rh);
        chk("post reset add latency", 16'(l1), 16'd2);
        chk("post reset add result", bus1.result, 16'h0002);
        release_res();

        // ena low blocks acceptance
        ena = 1'b0;
        drive(1'b1, 3'd0, 8'h03, 8'h04, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ena0 cmd_ready", {15'd0, bus1.cmd_ready}, 16'h0000);
            chk("ena0 res_valid", {15'd0, bus1.res_valid}, 16'h0000);
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        ena = 1'b1;
        tick();
        chk("ena0 no accept", {15'd0, bus1.res_valid}, 16'h0000);

        // Randomised traffic, including ena drops mid-operation
        for (int k = 0; k < 400; k++) begin
            ena = (($urandom % 8) != 0);
            drive(1'($urandom % 2), 3'($urandom % 8), 8'($urandom % 256),
                  8'($urandom % 256), 1'(($urandom % 3) != 0));
            tick();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
